// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: bubble word, opcodes shared with the decoder,
// fetch FSM state encoding and PC arithmetic.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [6:0]  OPC_HALT   = 7'b1111111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StWait      = 3'd2,
        StWaitStale = 3'd3,
        StHold      = 3'd4,
        StHalted    = 3'd5
    } fetch_state_e;

    // Wraps modulo 2^32 by construction.
    function automatic logic [31:0] next_pc(input logic [31:0] cur);
        return cur + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: {valid, instr, pc, pc4} with async clear,
// hold on stall and bubble insertion on flush or when nothing is loaded.
module fetch_stage_if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_pc4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
            pc4   <= '0;
        end else if (flush || (!hold && !load)) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
            pc4   <= '0;
        end else if (!hold) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
            pc4   <= d_pc4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one-outstanding imem requests,
// parks a response in a skid buffer under stall, and feeds the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        hlt,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        halted
);
    import fetch_stage_pkg::*;

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;

    logic         active;
    logic         redirect;
    logic         halt_now;
    logic         fetch_issue;
    logic         ifid_load;
    logic         ifid_hold;
    logic [31:0]  ifid_instr_d;
    logic [31:0]  ifid_pc_d;

    assign active      = (state != StHalted);
    assign redirect    = redirect_valid && active;
    // A redirect in the same cycle means the halt word is on the wrong path.
    assign halt_now    = active && hlt && if_id_valid && !redirect_valid;
    assign fetch_issue = (state == StFetch) && !stall;

    assign imem_req  = fetch_issue;
    assign imem_addr = pc;
    assign halted    = (state == StHalted);

    assign ifid_load    = ((state == StWait) && imem_rvalid) || (state == StHold);
    assign ifid_hold    = stall || halt_now || !active;
    assign ifid_instr_d = (state == StHold) ? skid_instr : imem_rdata;
    assign ifid_pc_d    = (state == StHold) ? skid_pc : pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            pc         <= RESET_PC;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
        end else if (redirect) begin
            pc <= redirect_pc & 32'hFFFF_FFFC;
            // Any response still owed by memory belongs to the old path.
            unique case (state)
                StFetch:             state <= fetch_issue ? StWaitStale : StFetch;
                StWait, StWaitStale: state <= imem_rvalid ? StFetch : StWaitStale;
                default:             state <= StFetch;
            endcase
        end else if (halt_now) begin
            state <= StHalted;
        end else begin
            unique case (state)
                StIdle: state <= StFetch;
                StFetch: begin
                    if (fetch_issue) state <= StWait;
                end
                StWait: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= pc;
                            state      <= StHold;
                        end else begin
                            pc    <= next_pc(pc);
                            state <= StFetch;
                        end
                    end
                end
                StHold: begin
                    if (!stall) begin
                        pc    <= next_pc(pc);
                        state <= StFetch;
                    end
                end
                StWaitStale: begin
                    if (imem_rvalid) state <= StFetch;
                end
                default: ;
            endcase
        end
    end

    fetch_stage_if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (redirect),
        .hold   (ifid_hold),
        .load   (ifid_load),
        .d_instr(ifid_instr_d),
        .d_pc   (ifid_pc_d),
        .d_pc4  (next_pc(ifid_pc_d)),
        .valid  (if_id_valid),
        .instr  (if_id_instr),
        .pc     (if_id_pc),
        .pc4    (if_id_pc4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: variable-latency memory model, decoder halt
// model, and hand-computed expectations checked on the falling clock edge.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        hlt;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        halted;

    int          n_tests = 0;
    int          n_fail = 0;
    int          mem_lat = 1;
    logic        halt_en = 1'b0;
    logic [31:0] halt_addr = '0;
    logic        stray = 1'b0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .hlt           (hlt),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Decoder model: flags the halt opcode on a valid IF/ID word.
    assign hlt = if_id_valid && (if_id_instr[6:0] == OPC_HALT);

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
        return {~a[24:0], 7'h13};
    endfunction

    // Memory: request sampled just before the rising edge, answered mem_lat cycles later.
    always begin : mem_model
        logic        req_s;
        logic        stray_s;
        logic [31:0] addr_s;
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        @(negedge clk);
        #4;
        req_s   = imem_req;
        addr_s  = imem_addr;
        stray_s = stray;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (req_s) begin
                pend  = 1'b1;
                cnt   = mem_lat;
                paddr = addr_s;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_at(paddr);
                    pend        = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
        end
        if (stray_s) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BE13;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_en        = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        check({tag, "_instr"}, if_id_instr, 32'h0000_0013);
        check({tag, "_pc"}, if_id_pc, 32'd0);
        check({tag, "_pc4"}, if_id_pc4, 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr, input int budget);
        int n = 0;
        while (!imem_req && n < budget) begin
            tick();
            n++;
        end
        if (!imem_req) check({tag, "_timeout"}, 32'(imem_req), 32'd1);
        else check(tag, imem_addr, exp_addr);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc, input int budget);
        int n = 0;
        logic [31:0] exp_pc4;
        exp_pc4 = exp_pc + 32'd4;
        while (!if_id_valid && n < budget) begin
            tick();
            n++;
        end
        if (!if_id_valid) begin
            check({tag, "_timeout"}, 32'(if_id_valid), 32'd1);
        end else begin
            check({tag, "_pc"}, if_id_pc, exp_pc);
            check({tag, "_pc4"}, if_id_pc4, exp_pc4);
            check({tag, "_instr"}, if_id_instr, word_at(exp_pc));
        end
    endtask

    initial begin
        int req_cnt;
        int n;

        // Reset values
        mem_lat = 1;
        rst_n   = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        rst_n = 1'b1;

        // 1: latency 1, one request every second cycle, IF/ID valid for one cycle each
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t1_req", 32'(imem_req), 32'(k % 2));
            if (k % 2 == 1) check("t1_addr", imem_addr, 32'(4 * ((k - 1) / 2)));
            check("t1_valid", 32'(if_id_valid), 32'((k == 3) || (k == 5)));
            if (k == 3 || k == 5) begin
                check("t1_pc", if_id_pc, 32'(4 * ((k - 3) / 2)));
                check("t1_pc4", if_id_pc4, 32'(4 * ((k - 3) / 2) + 4));
                check("t1_instr", if_id_instr, word_at(32'(4 * ((k - 3) / 2))));
            end
        end

        // 2: stall for 3 cycles while the word for 0x8 arrives (skid), then
        //    stall while IF/ID holds a valid word
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("t2_req_stall", 32'(imem_req), 32'd0);
            check("t2_valid_stall", 32'(if_id_valid), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("t2_valid_out", 32'(if_id_valid), 32'd1);
        check("t2_pc_out", if_id_pc, 32'h8);
        check("t2_instr_out", if_id_instr, word_at(32'h8));
        check("t2_req_next", 32'(imem_req), 32'd1);
        check("t2_addr_next", imem_addr, 32'hC);
        stall = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick();
            check("t2_hold_valid", 32'(if_id_valid), 32'd1);
            check("t2_hold_pc", if_id_pc, 32'h8);
            check("t2_hold_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("t2_bubble", 32'(if_id_valid), 32'd0);
        tick();
        check("t2_next_valid", 32'(if_id_valid), 32'd1);
        check("t2_next_pc", if_id_pc, 32'hC);

        // 3: redirect to 0x103 while a latency-3 request is outstanding
        mem_lat = 3;
        do_reset();
        tick();
        check("t3_req0", imem_addr, 32'h0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        check("t3_bubble_a", 32'(if_id_valid), 32'd0);
        check("t3_noreq_a", 32'(imem_req), 32'd0);
        tick();
        check("t3_bubble_b", 32'(if_id_valid), 32'd0);
        check("t3_noreq_b", 32'(imem_req), 32'd0);
        tick();
        check("t3_bubble_c", 32'(if_id_valid), 32'd0);
        check("t3_req_new", 32'(imem_req), 32'd1);
        check("t3_addr_new", imem_addr, 32'h100);
        wait_valid("t3_first", 32'h100, 10);

        // 4a: halt word at 0x8 stops fetching for good
        mem_lat = 1;
        do_reset();
        halt_en   = 1'b1;
        halt_addr = 32'h8;
        n = 0;
        while (!(if_id_valid && if_id_instr == 32'hFFFF_FFFF) && n < 20) begin
            tick();
            n++;
        end
        check("t4_halt_seen", if_id_instr, 32'hFFFF_FFFF);
        check("t4_not_yet", 32'(halted), 32'd0);
        tick();
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_hold_instr", if_id_instr, 32'hFFFF_FFFF);
        check("t4_hold_valid", 32'(if_id_valid), 32'd1);
        req_cnt = 0;
        repeat (20) begin
            tick();
            if (imem_req) req_cnt++;
        end
        check("t4_no_req", 32'(req_cnt), 32'd0);
        check("t4_still_halted", 32'(halted), 32'd1);
        check("t4_still_instr", if_id_instr, 32'hFFFF_FFFF);

        // 4b: same halt word with a redirect in that cycle is wrong-path
        do_reset();
        halt_en   = 1'b1;
        halt_addr = 32'h8;
        n = 0;
        while (!(if_id_valid && if_id_instr == 32'hFFFF_FFFF) && n < 20) begin
            tick();
            n++;
        end
        check("t4b_halt_seen", if_id_instr, 32'hFFFF_FFFF);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        check("t4b_not_halted", 32'(halted), 32'd0);
        check("t4b_bubble", 32'(if_id_valid), 32'd0);
        wait_req("t4b_req", 32'h40, 10);
        wait_valid("t4b_first", 32'h40, 10);
        check("t4b_not_halted_end", 32'(halted), 32'd0);

        // 5: reset mid-WAIT, stray response while leaving reset
        mem_lat = 3;
        do_reset();
        tick();
        tick();
        rst_n = 1'b0;
        stray = 1'b1;
        #1;
        check_reset_vals("t5_async");
        tick();
        stray = 1'b0;
        rst_n = 1'b1;
        tick();
        check("t5_req", 32'(imem_req), 32'd1);
        check("t5_addr", imem_addr, 32'h0);
        check("t5_no_stray", 32'(if_id_valid), 32'd0);
        wait_valid("t5_first", 32'h0, 10);

        // 6: PC wraps from 0xFFFF_FFFC to 0
        mem_lat = 1;
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        wait_req("t6_top", 32'hFFFF_FFFC, 10);
        wait_valid("t6_top", 32'hFFFF_FFFC, 10);
        wait_req("t6_wrap", 32'h0, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
